// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package regfile_pkg;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int ZERO_REG = 0;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;
endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot with a valid/ready input and a pop from the arbiter.
module wb_slot #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              pop,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    logic              full_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // A slot being drained this cycle may be refilled on the same edge.
    assign in_ready = !full_q || pop;
    assign full     = full_q;
    assign addr     = addr_q;
    assign data     = data_q;

    // Fill on handshake, empty on pop; an accept on the pop edge keeps the slot full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (in_valid && in_ready) begin
            full_q <= 1'b1;
            addr_q <= in_addr;
            data_q <= in_data;
        end else if (pop) begin
            full_q <= 1'b0;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback.
// Optional forwarding compare is built when REGFILE_WB_FWD_EN is defined.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              fwd_hit_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data
);
    logic              alu_full, mem_full;
    logic [ADDR_W-1:0] alu_saddr, mem_saddr;
    logic [DATA_W-1:0] alu_sdata, mem_sdata;
    logic              gnt_alu, gnt_mem, same_addr;
    grant_t            last_grant_q, last_grant_d;
    logic              coll_pend_q, coll_pend_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_alu_slot (
        .clk(clk), .rst(rst),
        .in_valid(alu_valid), .in_addr(alu_addr), .in_data(alu_data), .in_ready(alu_ready),
        .pop(gnt_alu), .full(alu_full), .addr(alu_saddr), .data(alu_sdata)
    );

    wb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem_slot (
        .clk(clk), .rst(rst),
        .in_valid(mem_valid), .in_addr(mem_addr), .in_data(mem_data), .in_ready(mem_ready),
        .pop(gnt_mem), .full(mem_full), .addr(mem_saddr), .data(mem_sdata)
    );

    assign same_addr = alu_full && mem_full && (alu_saddr == mem_saddr);

    // Grant selection: a pending same-address ALU write goes first, then collision
    // ordering (older MEM value before younger ALU), then round-robin on contention.
    // last_grant only moves on contested grants and on the collision's ALU follow-up.
    always_comb begin
        gnt_alu      = 1'b0;
        gnt_mem      = 1'b0;
        last_grant_d = last_grant_q;
        coll_pend_d  = 1'b0;
        if (coll_pend_q) begin
            gnt_alu      = alu_full;
            last_grant_d = GRANT_ALU;
        end else if (alu_full && mem_full) begin
            if (same_addr) begin
                gnt_mem     = 1'b1;
                coll_pend_d = 1'b1;
            end else if (last_grant_q == GRANT_MEM) begin
                gnt_alu      = 1'b1;
                last_grant_d = GRANT_ALU;
            end else begin
                gnt_mem      = 1'b1;
                last_grant_d = GRANT_MEM;
            end
        end else begin
            gnt_alu = alu_full;
            gnt_mem = mem_full;
        end
        gnt_addr = gnt_alu ? alu_saddr : mem_saddr;
        gnt_data = gnt_alu ? alu_sdata : mem_sdata;
    end

    // Arbiter state and registered write port; writes to r0 are granted but suppressed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= GRANT_MEM;
            coll_pend_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            coll_pend_q  <= coll_pend_d;
            wr_en_q      <= (gnt_alu || gnt_mem) && (gnt_addr != ADDR_W'(ZERO_REG));
            if (gnt_alu || gnt_mem) begin
                wr_addr_q <= gnt_addr;
                wr_data_q <= gnt_data;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = alu_full || mem_full || wr_en_q;

`ifdef REGFILE_WB_FWD_EN
    // Read-during-write bypass: the register file commits wr_data at the end of this cycle.
    assign fwd_hit_a = wr_en_q && (wr_addr_q == rd_addr_a) && (rd_addr_a != ADDR_W'(ZERO_REG));
    assign fwd_hit_b = wr_en_q && (wr_addr_q == rd_addr_b) && (rd_addr_b != ADDR_W'(ZERO_REG));
    assign fwd_data  = wr_data_q;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_addr_a, rd_addr_b};
    assign fwd_hit_a = 1'b0;
    assign fwd_hit_b = 1'b0;
    assign fwd_data  = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (honours REGFILE_WB_FWD_EN).
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_addr = '0, mem_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready, wr_en, busy, fwd_hit_a, fwd_hit_b;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, fwd_data;
    logic [31:0] rf [32];
    int          n_cmp = 0;
    int          n_bad = 0;

`ifdef REGFILE_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    // Register file model fed by the write port.
    initial for (int i = 0; i < 32; i++) rf[i] = '0;
    always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_chk(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".en"}, 32'(wr_en), 32'(en));
        if (en) begin
            chk({tag, ".addr"}, 32'(wr_addr), 32'(a));
            chk({tag, ".data"}, wr_data, d);
        end
    endtask

    initial begin
        // Reset held 2 edges with a request pending
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
        step(); step();
        rst = 1'b1; alu_valid = 1'b0;
        chk("rst.wr_en", 32'(wr_en), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.alu_ready", 32'(alu_ready), 1);
        chk("rst.mem_ready", 32'(mem_ready), 1);
        chk("rst.wr_addr", 32'(wr_addr), 0);
        chk("rst.wr_data", wr_data, 0);
        chk("rst.fwd_a", 32'(fwd_hit_a), 0);

        // Single ALU write
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h55;
        step(); alu_valid = 1'b0;
        chk("single.busy", 32'(busy), 1);
        chk("single.en0", 32'(wr_en), 0);
        step(); wr_chk("single", 1'b1, 5'd9, 32'h55);
        step(); chk("single.idle", 32'(wr_en), 0);
        chk("single.hold", 32'(wr_addr), 9);

        // Contention: ALU wins first after reset
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hF;
        mem_valid = 1'b1; mem_addr = 5'd11; mem_data = 32'hC;
        step(); alu_valid = 1'b0; mem_valid = 1'b0;
        step(); wr_chk("cont1.alu", 1'b1, 5'd10, 32'hF);
        step(); wr_chk("cont1.mem", 1'b1, 5'd11, 32'hC);
        step(); chk("cont1.idle", 32'(wr_en), 0);

        // Next collision: MEM first
        alu_valid = 1'b1; alu_addr = 5'd13; alu_data = 32'h1;
        mem_valid = 1'b1; mem_addr = 5'd14; mem_data = 32'h2;
        step(); alu_valid = 1'b0; mem_valid = 1'b0;
        step(); wr_chk("cont2.mem", 1'b1, 5'd14, 32'h2);
        step(); wr_chk("cont2.alu", 1'b1, 5'd13, 32'h1);
        step();

        // Same address: MEM value then ALU value
        alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hA;
        mem_valid = 1'b1; mem_addr = 5'd12; mem_data = 32'hB;
        step(); alu_valid = 1'b0; mem_valid = 1'b0;
        step(); wr_chk("same.mem", 1'b1, 5'd12, 32'hB);
        step(); wr_chk("same.alu", 1'b1, 5'd12, 32'hA);
        step(); chk("same.rf12", rf[12], 32'hA);

        // Back-to-back ALU stream, 4 writes
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; alu_addr = 5'(20 + i); alu_data = 32'(32'h100 + i);
            chk($sformatf("b2b.ready%0d", i), 32'(alu_ready), 1);
            step();
            if (i > 0) wr_chk($sformatf("b2b.w%0d", i - 1), 1'b1, 5'(19 + i), 32'(32'hFF + i));
        end
        alu_valid = 1'b0;
        step(); wr_chk("b2b.w3", 1'b1, 5'd23, 32'h103);
        step(); chk("b2b.idle", 32'(wr_en), 0);

        // Address 0 accepted but not written
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h77;
        step(); alu_valid = 1'b0;
        chk("r0.busy", 32'(busy), 1);
        step(); chk("r0.no_en", 32'(wr_en), 0);
        chk("r0.rf0", rf[0], 0);

        // Reset mid-stream drops pending MEM slot
        mem_valid = 1'b1; mem_addr = 5'd5; mem_data = 32'h99;
        step(); mem_valid = 1'b0; rst = 1'b0;
        step(); rst = 1'b1;
        chk("mrst.wr_en", 32'(wr_en), 0);
        chk("mrst.busy", 32'(busy), 0);
        chk("mrst.mem_ready", 32'(mem_ready), 1);
        step(); chk("mrst.no_write", 32'(wr_en), 0);
        chk("mrst.rf5", rf[5], 0);

        // Forwarding compare
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'h33;
        step(); alu_valid = 1'b0;
        rd_addr_a = 5'd10; rd_addr_b = 5'd0;
        step(); wr_chk("fwd.wr", 1'b1, 5'd10, 32'h33);
        chk("fwd.hit_a", 32'(fwd_hit_a), 32'(FWD));
        chk("fwd.hit_b", 32'(fwd_hit_b), 0);
        chk("fwd.data", fwd_data, FWD ? 32'h33 : 32'h0);
        step(); chk("fwd.hit_a_idle", 32'(fwd_hit_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
